// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: paces the PC, runs the valid-hold memory handshake,
// buffers fetched words in an IR plus skid entry, and traps bus errors/timeouts.
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_addr,
  output logic        pc_stall,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  input  logic        ir_ready,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_BUS  = 2'b01,
    CAUSE_TMO  = 2'b10
  } cause_t;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;
  logic [31:0]   held_addr;
  logic          skid_valid;
  logic [31:0]   skid_data;
  logic [31:0]   skid_pc;
  cause_t        cause_q;

  logic wait_phase;
  logic ir_free;
  logic accept;
  logic bus_err;
  logic tmo_hit;

  assign wait_phase = (state == S_REQ) || (state == S_DRAIN);
  assign ir_free    = !ir_valid || ir_ready;
  assign accept     = (state == S_REQ) && imem_ack && !imem_err && !redirect;
  assign bus_err    = (state == S_REQ) && imem_ack && imem_err && !redirect;
  assign tmo_hit    = wait_phase && !imem_ack && !redirect &&
                      (tmo_cnt == CW'(TIMEOUT - 1));

  // The PC is frozen in REQ, so pc_addr is already stable there; DRAIN needs the
  // shadow copy because the PC has jumped past the abandoned request.
  assign imem_req    = wait_phase;
  assign imem_addr   = (state == S_DRAIN) ? held_addr : pc_addr;
  assign pc_stall    = !(accept || redirect);
  assign fault_cause = cause_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_next   = state;
    tmo_cnt_next = '0;
    if (redirect) begin
      state_next = (wait_phase && !imem_ack) ? S_DRAIN : S_REQ;
    end else begin
      unique case (state)
        S_IDLE:  state_next = S_REQ;
        S_REQ: begin
          if (bus_err)                  state_next = S_FAULT;
          else if (accept && !ir_free)  state_next = S_HOLD;
          else if (tmo_hit)             state_next = S_FAULT;
        end
        S_HOLD:  if (ir_ready) state_next = S_REQ;
        S_DRAIN: begin
          if (imem_ack)     state_next = S_REQ;
          else if (tmo_hit) state_next = S_FAULT;
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_IDLE;
      endcase
      if (wait_phase && !imem_ack && !tmo_hit) tmo_cnt_next = tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_cnt_next;
    end
  end

  // NOTE: pure datapath registers carry no reset; their qualifiers (state, skid_valid)
  // guarantee they are written before they are ever observed.
  always_ff @(posedge clk) begin
    if (state == S_REQ) held_addr <= pc_addr;
    if (accept && !ir_free) begin
      skid_data <= imem_rdata;
      skid_pc   <= pc_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_fault <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else if (redirect) begin
      fetch_fault <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else if (bus_err) begin
      fetch_fault <= 1'b1;
      cause_q     <= CAUSE_BUS;
    end else if (tmo_hit) begin
      fetch_fault <= 1'b1;
      cause_q     <= CAUSE_TMO;
    end
  end

  // IR/skid occupancy; a redirect flushes both, and any response in that cycle is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_valid   <= 1'b0;
      ir_data    <= '0;
      ir_pc      <= '0;
      skid_valid <= 1'b0;
    end else if (redirect) begin
      ir_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (accept && ir_free) begin
      ir_valid <= 1'b1;
      ir_data  <= imem_rdata;
      ir_pc    <= pc_addr;
    end else if (accept) begin
      skid_valid <= 1'b1;
    end else if ((state == S_HOLD) && ir_ready && skid_valid) begin
      ir_valid   <= 1'b1;
      ir_data    <= skid_data;
      ir_pc      <= skid_pc;
      skid_valid <= 1'b0;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios, then randomized traffic
// checked against an instruction-stream model (contiguous PCs, restart at redirect target).
module tb_fetch_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_stall;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  logic [31:0] target;
  int          n_checks = 0;
  int          n_errors = 0;

  // random-phase model state
  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic [31:0] tgt;
  logic        prev_pend;
  logic        rd, ack, rdy;
  int          mem_wait, mem_delay, consumed;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_stall    (pc_stall),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd_i, input logic [31:0] tgt_i, input logic ack_i,
                       input logic err_i, input logic rdy_i);
    redirect = rd_i;
    target   = tgt_i;
    imem_ack = ack_i;
    imem_err = err_i;
    ir_ready = rdy_i;
    #1;
  endtask

  // One clock: the pc block advances, jumps or holds according to pc_stall/redirect.
  task automatic tick();
    logic        stall_s, redir_s;
    logic [31:0] tgt_s;
    stall_s = pc_stall;
    redir_s = redirect;
    tgt_s   = target;
    @(posedge clk);
    #1;
    if (!stall_s) pc_addr = redir_s ? tgt_s : pc_addr + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    pc_addr = 32'h40;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_stall", pc_stall, 1);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h40);
    check("rst_irvalid", ir_valid, 0);
    check("rst_irdata", ir_data, 0);
    check("rst_irpc", ir_pc, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_cause", fault_cause, 0);

    pc_addr = 32'h0;
    rst_n   = 1'b1;
    drive(0, 0, 0, 0, 0);
    check("idle_req", imem_req, 0);
    tick();

    // zero-wait memory, decode always ready
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1);
      check("zw_req", imem_req, 1);
      check("zw_addr", imem_addr, 32'(4 * i));
      check("zw_stall", pc_stall, 0);
      if (i > 0) check("zw_irpc", ir_pc, 32'(4 * (i - 1)));
      tick();
    end
    check("zw_irvalid", ir_valid, 1);
    check("zw_irpc_last", ir_pc, 32'd8);
    check("zw_irdata", ir_data, mem_word(32'd8));

    // IR full and not ready: the ack of 12 lands in the skid
    drive(0, 0, 1, 0, 0);
    check("skid_addr", imem_addr, 32'd12);
    check("skid_stall", pc_stall, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("hold_req", imem_req, 0);
    check("hold_stall", pc_stall, 1);
    check("hold_pc", pc_addr, 32'd16);
    check("hold_irpc", ir_pc, 32'd8);
    tick();
    drive(0, 0, 0, 0, 1);
    check("hold_req2", imem_req, 0);
    tick();

    // redirect while the request at 16 is outstanding
    drive(1, 32'd80, 0, 0, 1);
    check("unskid_irpc", ir_pc, 32'd12);
    check("unskid_irdata", ir_data, mem_word(32'd12));
    check("rd_req", imem_req, 1);
    check("rd_addr", imem_addr, 32'd16);
    check("rd_stall", pc_stall, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    check("drain_req", imem_req, 1);
    check("drain_addr", imem_addr, 32'd16);
    check("drain_irvalid", ir_valid, 0);
    check("drain_pc", pc_addr, 32'd80);
    tick();
    drive(0, 0, 1, 0, 1);
    check("drain_ack_addr", imem_addr, 32'd16);
    check("drain_ack_stall", pc_stall, 1);
    tick();
    drive(0, 0, 1, 0, 1);
    check("post_drain_irvalid", ir_valid, 0);
    check("post_drain_addr", imem_addr, 32'd80);
    check("post_drain_stall", pc_stall, 0);
    tick();

    // redirect in the same cycle as a good ack
    drive(1, 32'd20, 1, 0, 1);
    check("tgt_irpc", ir_pc, 32'd80);
    check("tgt_irdata", ir_data, mem_word(32'd80));
    check("rdack_stall", pc_stall, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    check("rdack_irvalid", ir_valid, 0);
    check("rdack_req", imem_req, 1);
    check("rdack_addr", imem_addr, 32'd20);
    tick();

    // bus error at 24
    drive(0, 0, 1, 1, 0);
    check("err_addr", imem_addr, 32'd24);
    check("err_stall", pc_stall, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      check("flt_fault", fetch_fault, 1);
      check("flt_cause", fault_cause, 2'b01);
      check("flt_req", imem_req, 0);
      check("flt_stall", pc_stall, 1);
      check("flt_irpc", ir_pc, 32'd20);
      check("flt_irvalid", ir_valid, 1);
      check("flt_pc", pc_addr, 32'd24);
      tick();
    end
    drive(1, 32'h100, 0, 0, 1);
    check("flt_rd_stall", pc_stall, 0);
    tick();

    // timeout after exactly TMO request cycles
    for (int k = 0; k < int'(TMO); k++) begin
      drive(0, 0, 0, 0, 1);
      check("tmo_fault", fetch_fault, 0);
      check("tmo_cause", fault_cause, 2'b00);
      check("tmo_req", imem_req, 1);
      check("tmo_addr", imem_addr, 32'h100);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    check("tmo_fault_set", fetch_fault, 1);
    check("tmo_cause_set", fault_cause, 2'b10);
    check("tmo_req_drop", imem_req, 0);
    check("tmo_stall", pc_stall, 1);
    tick();

    // reset in the middle of a fetch
    drive(1, 32'h200, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("mid_req", imem_req, 1);
    check("mid_irpc", ir_pc, 32'h200);
    rst_n = 1'b0;
    #1;
    check("mrst_stall", pc_stall, 1);
    check("mrst_req", imem_req, 0);
    check("mrst_addr", imem_addr, 32'h204);
    check("mrst_irvalid", ir_valid, 0);
    check("mrst_irdata", ir_data, 0);
    check("mrst_irpc", ir_pc, 0);
    check("mrst_fault", fetch_fault, 0);
    check("mrst_cause", fault_cause, 0);
    pc_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the instruction-stream model
    exp_pc    = 32'h0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    mem_wait  = 0;
    mem_delay = int'($urandom_range(0, 2));
    consumed  = 0;
    for (int n = 0; n < 3000; n++) begin
      rd  = ($urandom_range(0, 15) == 0);
      tgt = $urandom_range(0, 1023) << 2;
      rdy = ($urandom_range(0, 9) < 7);
      ack = imem_req && (mem_wait >= mem_delay);
      drive(rd, tgt, ack, 0, rdy);
      if (prev_pend) begin
        check("rnd_req_stable", imem_req, 1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      check("rnd_no_fault", fetch_fault, 0);
      if (ir_valid && ir_ready) begin
        check("rnd_irpc", ir_pc, exp_pc);
        check("rnd_irdata", ir_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (rd) exp_pc = tgt;
      if (imem_req) begin
        if (ack) begin
          mem_wait  = 0;
          mem_delay = int'($urandom_range(0, 2));
        end else begin
          mem_wait++;
        end
      end
      prev_pend = imem_req && !ack;
      prev_addr = imem_addr;
      tick();
    end
    check("rnd_progress", 32'(consumed >= 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
